// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between the keyboard controller and the PS/2 host transmitter.
// master issues tx_valid/tx_data; slave reports tx_ready and the done/error pulses.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output tx_done,
        output tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command sender: inhibit, request-to-send, 11-bit frame, ACK check.
// Latency: INHIBIT_CYCLES+2 cycles to clock release, then device-paced; pin edge to data update <=4 cycles.
// Backpressure: tx_ready=0 from acceptance until the done/error pulse; tx_valid while busy is dropped.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2700,
    parameter int TIMEOUT_CYCLES = 405000,
    parameter int CNT_WIDTH      = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    ps2_host_tx_if.slave    tx,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    output logic            ps2_clk_pulldown,
    output logic            ps2_data_pulldown
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_ERR
    } state_t;

    localparam logic [CNT_WIDTH-1:0] INH_LAST = CNT_WIDTH'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WD_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [3:0]             bit_cnt;
    logic [8:0]             frame;
    logic [1:0]             clk_sync;
    logic [1:0]             data_sync;
    logic                   clk_prev;
    logic                   clk_fall;

    // Idle bus is high, so the synchronisers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_fall = clk_prev & ~clk_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            cnt               <= '0;
            bit_cnt           <= '0;
            frame             <= '0;
            tx.tx_ready       <= 1'b1;
            tx.tx_done        <= 1'b0;
            tx.tx_error       <= 1'b0;
            ps2_clk_pulldown  <= 1'b0;
            ps2_data_pulldown <= 1'b0;
        end else begin
            tx.tx_done  <= 1'b0;
            tx.tx_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx.tx_ready       <= 1'b1;
                    ps2_clk_pulldown  <= 1'b0;
                    ps2_data_pulldown <= 1'b0;
                    if (tx.tx_valid && tx.tx_ready) begin
                        frame            <= {~^tx.tx_data, tx.tx_data};
                        cnt              <= '0;
                        bit_cnt          <= '0;
                        tx.tx_ready      <= 1'b0;
                        ps2_clk_pulldown <= 1'b1;
                        state            <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        ps2_data_pulldown <= 1'b1;
                        state             <= S_REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    // Releasing the clock with data held low is the start bit.
                    ps2_clk_pulldown <= 1'b0;
                    cnt              <= '0;
                    bit_cnt          <= '0;
                    state            <= S_SEND;
                end
                S_SEND: begin
                    if (clk_fall) begin
                        cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            ps2_data_pulldown <= 1'b0;
                            state             <= S_ACK;
                        end else begin
                            ps2_data_pulldown <= ~frame[0];
                            frame             <= {1'b0, frame[8:1]};
                            bit_cnt           <= bit_cnt + 1'b1;
                        end
                    end else if (cnt == WD_LAST) begin
                        ps2_data_pulldown <= 1'b0;
                        state             <= S_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (clk_fall) begin
                        cnt   <= '0;
                        state <= data_sync[1] ? S_ERR : S_WAIT_IDLE;
                    end else if (cnt == WD_LAST) begin
                        state <= S_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_sync[1] && data_sync[1]) begin
                        tx.tx_done  <= 1'b1;
                        tx.tx_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else if (cnt == WD_LAST) begin
                        state <= S_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ERR: begin
                    ps2_clk_pulldown  <= 1'b0;
                    ps2_data_pulldown <= 1'b0;
                    tx.tx_error       <= 1'b1;
                    tx.tx_ready       <= 1'b1;
                    state             <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain PS/2 device model plus a completion scoreboard.
module tb_ps2_host_tx;

    localparam int INH = 2700;
    localparam int TMO = 4000;
    localparam int H   = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic clk_pd, data_pd;
    logic ps2_clk_w, ps2_data_w;

    assign ps2_clk_w  = dev_clk  & ~clk_pd;
    assign ps2_data_w = dev_data & ~data_pd;

    ps2_host_tx_if tx_if();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .CNT_WIDTH      (19)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .tx                (tx_if.slave),
        .ps2_clk           (ps2_clk_w),
        .ps2_data          (ps2_data_w),
        .ps2_clk_pulldown  (clk_pd),
        .ps2_data_pulldown (data_pd)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit         is_err;
        bit         chk_bits;
        logic [9:0] bits;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] cap_bits;
    int         alone_cnt;
    int         both_cnt;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push(bit is_err, bit chk_bits, logic [9:0] bits);
        exp_t e;
        e.is_err   = is_err;
        e.chk_bits = chk_bits;
        e.bits     = bits;
        sb.push_back(e);
    endfunction

    // Monitor: every done/error pulse consumes one expected completion.
    exp_t m_e;
    always @(negedge clk) begin
        if (rst_n && (tx_if.tx_done || tx_if.tx_error)) begin
            chk("done_error_exclusive", 32'(tx_if.tx_done & tx_if.tx_error), 0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_completion: done=%0b error=%0b with nothing expected",
                         tx_if.tx_done, tx_if.tx_error);
            end else begin
                m_e = sb.pop_front();
                chk("result_is_error", 32'(tx_if.tx_error), 32'(m_e.is_err));
                chk("ready_with_pulse", 32'(tx_if.tx_ready), 1);
                if (m_e.chk_bits) chk("line_bits", 32'(cap_bits), 32'(m_e.bits));
                if (m_e.is_err) chk("pulldowns_on_error", 32'({clk_pd, data_pd}), 0);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int t = 0;
        while (!tx_if.tx_ready && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) chk("send_ready_timeout", 1, 0);
        tx_if.tx_data  = b;
        tx_if.tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_if.tx_valid = 1'b0;
        @(negedge clk);
        chk("ready_low_after_accept", 32'(tx_if.tx_ready), 0);
        chk("clk_pd_after_accept", 32'(clk_pd), 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!tx_if.tx_ready && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) chk("wait_idle_timeout", 1, 0);
        repeat (5) @(negedge clk);
    endtask

    // Device: waits for start bit with clock released, then clocks nedges falling edges.
    task automatic dev_run(input int nedges, input bit ack, input int rst_at);
        int t = 0;
        cap_bits  = '0;
        alone_cnt = 0;
        both_cnt  = 0;
        while (!(clk_pd == 1'b0 && data_pd == 1'b1) && t < 10000) begin
            if (clk_pd && !data_pd) alone_cnt++;
            if (clk_pd && data_pd)  both_cnt++;
            @(negedge clk);
            t++;
        end
        if (t >= 10000) begin
            chk("device_start_timeout", 1, 0);
            return;
        end
        repeat (10) @(negedge clk);
        for (int k = 1; k <= nedges; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_clk_pd", 32'(clk_pd), 0);
                chk("rst_data_pd", 32'(data_pd), 0);
                chk("rst_ready", 32'(tx_if.tx_ready), 1);
                dev_clk = 1'b1;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            dev_clk = 1'b1;
            if (k <= 10) cap_bits[k-1] = ps2_data_w;
            if (k == 10 && ack) dev_data = 1'b0;
            repeat (H) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int t;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(tx_if.tx_ready), 1);
        chk("reset_done", 32'(tx_if.tx_done), 0);
        chk("reset_error", 32'(tx_if.tx_error), 0);
        chk("reset_clk_pd", 32'(clk_pd), 0);
        chk("reset_data_pd", 32'(data_pd), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0xFF, ACK: data bits all high, parity 1, stop 1
        push(1'b0, 1'b1, 10'b1_1_11111111);
        send(8'hFF);
        dev_run(11, 1'b1, 0);
        wait_idle();

        // 0xED, ACK, with a 0x00 request issued while busy that must be dropped
        push(1'b0, 1'b1, 10'b1_1_11101101);
        send(8'hED);
        fork
            dev_run(11, 1'b1, 0);
            begin
                repeat (100) @(negedge clk);
                tx_if.tx_data  = 8'h00;
                tx_if.tx_valid = 1'b1;
                @(posedge clk);
                #1 tx_if.tx_valid = 1'b0;
            end
        join
        chk("inhibit_alone_cycles", 32'(alone_cnt), 32'(INH));
        chk("req_overlap_cycles", 32'(both_cnt), 1);
        wait_idle();

        // 0xF4, device NACKs by leaving data high
        push(1'b1, 1'b1, 10'b1_0_11110100);
        send(8'hF4);
        dev_run(11, 1'b0, 0);
        wait_idle();

        // 0xFF, no device clocks: watchdog from SEND entry
        push(1'b1, 1'b0, 10'b0);
        send(8'hFF);
        t = 0;
        while (clk_pd && t < 10000) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (!tx_if.tx_error && t < TMO + 100) begin
            @(negedge clk);
            t++;
        end
        chk("watchdog_cycles", 32'(t), 32'(TMO + 1));
        wait_idle();

        // 0xFF, clock stops after 5 edges
        push(1'b1, 1'b0, 10'b0);
        send(8'hFF);
        dev_run(5, 1'b0, 0);
        wait_idle();

        // reset during edge 4, then a clean 0xF4
        send(8'hFF);
        dev_run(11, 1'b1, 4);
        repeat (5) @(negedge clk);
        push(1'b0, 1'b1, 10'b1_0_11110100);
        send(8'hF4);
        dev_run(11, 1'b1, 0);
        wait_idle();

        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 command transmitter. Replaces the fixed clock-inhibit pulse of the current keyboard top level with a complete request-to-send and frame engine, parametrised by inhibit length and watchdog timeout. Sends one command byte (e.g. 0xFF reset, 0xED LEDs, 0xF4 enable) to the keyboard through open-drain pulldown outputs. Checks the device acknowledge and reports done or error. Sits beside the receiver in the keyboard FPGA; the receiver must be held off while `tx_ready` is 0.

## Interface
- INHIBIT_CYCLES, 2700: cycles ps2 clk is held low before request-to-send (100 us @ 27 MHz)
- TIMEOUT_CYCLES, 405000: watchdog limit between device clock edges (15 ms @ 27 MHz)
- CNT_WIDTH, 19: width of the shared inhibit/watchdog counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock line (asynchronous)
- ps2_data  in  1  raw PS/2 data line (asynchronous)
- tx_valid  in  1  command byte request
- tx_data  in  8  command byte
- tx_ready  out  1  block idle; can accept a byte
- tx_done  out  1  one-cycle pulse: byte acknowledged and bus idle
- tx_error  out  1  one-cycle pulse: NACK or watchdog timeout
- ps2_clk_pulldown  out  1  1 = drive PS/2 clock low
- ps2_data_pulldown  out  1  1 = drive PS/2 data low

## Operation
- Every output is registered. Reset value: tx_ready=1 and all other outputs 0. Reset is async, so asserting rst_n mid-frame releases both lines immediately and returns the block to IDLE.
- Synchronise ps2_clk and ps2_data with 2 flops each. A falling edge is sync_prev=1 and sync=0, and is honoured only in SEND and ACK.
- Frame shift register, 9 bits: {parity, tx_data}. Parity is odd, computed as ~^tx_data. Bit counter is 4 bits.
- IDLE: tx_ready=1. When tx_valid&&tx_ready, latch the byte and parity, clear the counter, go to INHIBIT. A tx_valid seen while tx_ready=0 is ignored; there is no queue.
- INHIBIT: clk_pulldown=1, data_pulldown=0. Count up; when count==INHIBIT_CYCLES-1, go to REQ.
- REQ: clk_pulldown=1, data_pulldown=1 for exactly 1 cycle; this drives the start bit. Then go to SEND with the counter and bit index cleared.
- SEND: clk_pulldown=0. Falling edges k=1..9 drive data_pulldown = ~frame[k-1] (data bits LSB first, then parity). Falling edge 10 sets data_pulldown=0, which is the released stop bit. Then go to ACK.
- ACK: on the next falling edge, sample synced ps2_data. A 0 goes to WAIT_IDLE; a 1 means NACK and goes to ERR.
- WAIT_IDLE: when synced ps2_clk and ps2_data are both 1, pulse tx_done and go to IDLE.
- ERR: both pulldowns 0; pulse tx_error; go to IDLE.
- Watchdog applies in SEND, ACK and WAIT_IDLE. The counter clears on state entry and on every honoured falling edge. When count==TIMEOUT_CYCLES-1, go to ERR.
- tx_done and tx_error are never asserted in the same cycle.

## Timing
- The acceptance edge is N. tx_ready=0 and clk_pulldown=1 are visible from N+1.
- clk_pulldown stays high alone for exactly INHIBIT_CYCLES cycles, then for 1 cycle together with data_pulldown. It is released at N+INHIBIT_CYCLES+2.
- Pin falling edge to data_pulldown update: at most 4 clk cycles (2 sync, 1 detect, 1 register). This is well inside the 30 us low phase.
- tx_ready returns to 1 in the same cycle as the tx_done or tx_error pulse. A new byte can be accepted on the next edge.
- Edges caused by the block's own clk_pulldown (INHIBIT/REQ) are never counted.

## Test plan
- Send 0xFF with a device model that ACKs → data_pulldown pattern for bits is 0 eight times, parity 0 (line high), stop high. ACK low gives one tx_done pulse, then tx_ready=1.
- Send 0xED → line-level bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Check clk_pulldown high for exactly 2700 cycles, then a 1-cycle REQ overlap.
- Send 0xF4 with the model holding data high at the ACK edge → tx_error pulse, no tx_done, both pulldowns 0.
- Send 0xFF with the model generating no clocks → after 405000 cycles in SEND, tx_error pulses. Repeat with the clock stopping after 5 edges → same result.
- Drop rst_n during edge 4 of SEND → both pulldowns 0 immediately, tx_ready=1. A subsequent 0xF4 completes correctly.
- Pulse tx_valid with 0x00 during INHIBIT of a 0xED transfer → ignored; only 0xED is sent, with a single tx_done.
